rf_mp: RTL and testbench

- Parametrised multi-port integer register file; the next generation of the core's register file.
- Generalises data width, register count, read-port count and write-port count.
- Adds optional write-to-read bypass, a hardwired-zero option and a per-register busy scoreboard, so that issue logic can detect pending writebacks.
- Sits between decode/issue (read ports, busy marking) and the writeback stage(s) (write ports, busy clearing).

---
 rtl/rf_mp.sv | 91 +++++++++
 tb/tb_rf_mp.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rf_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass,
// a hardwired-zero register and a per-register busy scoreboard.
module rf_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_busy,
    input  logic                set_en,
    input  logic [AW-1:0]       set_addr,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Later loop iterations override earlier ones, so the higher write port wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && !(ZERO_REG != 0 && wa[k*AW +: AW] == '0)) begin
                    regs[wa[k*AW +: AW]] <= wd[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Set is applied after clear so a newly issued producer keeps its mark.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NWR; k++) begin
            if (we[k]) begin
                busy_d[wa[k*AW +: AW]] = 1'b0;
            end
        end
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    always_comb begin
        rd      = '0;
        rd_busy = '0;
        for (int j = 0; j < NRD; j++) begin
            rd[j*XLEN +: XLEN] = regs[ra[j*AW +: AW]];
            rd_busy[j]         = busy_q[ra[j*AW +: AW]];
            if (BYPASS != 0) begin
                for (int k = 0; k < NWR; k++) begin
                    if (we[k] && wa[k*AW +: AW] == ra[j*AW +: AW]) begin
                        rd[j*XLEN +: XLEN] = wd[k*XLEN +: XLEN];
                        rd_busy[j]         = 1'b0;
                    end
                end
            end
            if (ZERO_REG != 0 && ra[j*AW +: AW] == '0) begin
                rd[j*XLEN +: XLEN] = '0;
                rd_busy[j]         = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rf_mp.sv
// Directed bench for rf_mp: instance a (two write ports, bypass, zero reg)
// and instance b (one write port, no bypass, ordinary register 0).
module tb_rf_mp;

    logic        clk;
    logic        rst;

    logic [1:0]  a_we;
    logic [9:0]  a_wa;
    logic [63:0] a_wd;
    logic [9:0]  a_ra;
    logic [63:0] a_rd;
    logic [1:0]  a_rd_busy;
    logic        a_set_en;
    logic [4:0]  a_set_addr;
    logic [31:0] a_busy;

    logic [0:0]  b_we;
    logic [4:0]  b_wa;
    logic [31:0] b_wd;
    logic [9:0]  b_ra;
    logic [63:0] b_rd;
    logic [1:0]  b_rd_busy;
    logic        b_set_en;
    logic [4:0]  b_set_addr;
    logic [31:0] b_busy;

    int total = 0;
    int bad   = 0;

    rf_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .we(a_we), .wa(a_wa), .wd(a_wd), .ra(a_ra), .rd(a_rd),
        .rd_busy(a_rd_busy), .set_en(a_set_en), .set_addr(a_set_addr), .busy_vec(a_busy)
    );

    rf_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .we(b_we), .wa(b_wa), .wd(b_wd), .ra(b_ra), .rd(b_rd),
        .rd_busy(b_rd_busy), .set_en(b_set_en), .set_addr(b_set_addr), .busy_vec(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        a_we = '0; a_wa = '0; a_wd = '0; a_set_en = 1'b0; a_set_addr = '0;
        b_we = '0; b_wa = '0; b_wd = '0; b_set_en = 1'b0; b_set_addr = '0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        a_ra = '0;
        b_ra = '0;
        tick();
        rst = 1'b0;

        // Preload reg5 with its busy mark, then reset.
        a_we = 2'b01; a_wa = {5'd0, 5'd5}; a_wd = {32'd0, 32'hDEADBEEF};
        a_set_en = 1'b1; a_set_addr = 5'd5;
        b_we = 1'b1; b_wa = 5'd5; b_wd = 32'hDEADBEEF; b_set_en = 1'b1; b_set_addr = 5'd5;
        tick();
        idle();
        a_ra = {5'd0, 5'd5};
        b_ra = {5'd0, 5'd5};
        #1;
        chk("pre_rst_a_rd", a_rd[31:0], 32'hDEADBEEF);
        chk("pre_rst_a_busy", a_busy, 32'h0000_0020);
        chk("pre_rst_a_rd_busy", {31'd0, a_rd_busy[0]}, 32'd1);
        chk("pre_rst_b_busy", b_busy, 32'h0000_0020);

        rst = 1'b1;
        a_we = 2'b01; a_wa = {5'd0, 5'd5}; a_wd = {32'd0, 32'h11111111};
        a_set_en = 1'b1; a_set_addr = 5'd6;
        #1;
        chk("rst_cycle_bypass", a_rd[31:0], 32'h11111111);
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("post_rst_a_rd", a_rd[31:0], 32'h0);
        chk("post_rst_a_busy", a_busy, 32'h0);
        chk("post_rst_a_rd_busy", {31'd0, a_rd_busy[0]}, 32'd0);
        chk("post_rst_b_rd", b_rd[31:0], 32'h0);
        chk("post_rst_b_busy", b_busy, 32'h0);

        // Bypass on instance a.
        a_we = 2'b01; a_wa = {5'd0, 5'd7}; a_wd = {32'd0, 32'h12345678};
        a_ra = {5'd7, 5'd7};
        #1;
        chk("bypass_a_rd0", a_rd[31:0], 32'h12345678);
        chk("bypass_a_rd1", a_rd[63:32], 32'h12345678);
        tick();
        idle();
        #1;
        chk("stored_a_rd0", a_rd[31:0], 32'h12345678);

        // No bypass on instance b: old value this cycle, new value next.
        b_we = 1'b1; b_wa = 5'd7; b_wd = 32'hCAFEF00D;
        tick();
        b_we = 1'b1; b_wa = 5'd7; b_wd = 32'h12345678;
        b_ra = {5'd0, 5'd7};
        #1;
        chk("nobypass_b_same", b_rd[31:0], 32'hCAFEF00D);
        tick();
        idle();
        #1;
        chk("nobypass_b_next", b_rd[31:0], 32'h12345678);

        // Zero register.
        a_we = 2'b01; a_wa = {5'd0, 5'd0}; a_wd = {32'd0, 32'hFFFFFFFF};
        a_set_en = 1'b1; a_set_addr = 5'd0; a_ra = {5'd7, 5'd0};
        b_we = 1'b1; b_wa = 5'd0; b_wd = 32'hFFFFFFFF;
        b_set_en = 1'b1; b_set_addr = 5'd0; b_ra = {5'd7, 5'd0};
        #1;
        chk("zero_a_same", a_rd[31:0], 32'h0);
        chk("zero_a_busy_same", {31'd0, a_rd_busy[0]}, 32'd0);
        chk("zero_b_same", b_rd[31:0], 32'h0);
        tick();
        idle();
        #1;
        chk("zero_a_next", a_rd[31:0], 32'h0);
        chk("zero_a_busyvec", a_busy, 32'h0);
        chk("zero_b_next", b_rd[31:0], 32'hFFFFFFFF);
        chk("zero_b_busyvec", b_busy, 32'h0000_0001);
        chk("zero_b_rd_busy", {31'd0, b_rd_busy[0]}, 32'd1);
        chk("b_port1_r7", b_rd[63:32], 32'h12345678);

        // Dual-port write collision: higher port wins.
        a_we = 2'b11; a_wa = {5'd3, 5'd3}; a_wd = {32'h0000000B, 32'h0000000A};
        a_ra = {5'd7, 5'd3};
        #1;
        chk("collide_bypass", a_rd[31:0], 32'h0000000B);
        tick();
        idle();
        #1;
        chk("collide_stored", a_rd[31:0], 32'h0000000B);
        chk("a_port1_r7", a_rd[63:32], 32'h12345678);

        // Scoreboard ordering on r9.
        a_set_en = 1'b1; a_set_addr = 5'd9; a_ra = {5'd3, 5'd9};
        tick();
        idle();
        #1;
        chk("sb_set", a_busy, 32'h0000_0200);
        chk("sb_rd_busy_set", {31'd0, a_rd_busy[0]}, 32'd1);
        a_we = 2'b01; a_wa = {5'd0, 5'd9}; a_wd = {32'd0, 32'h00000099};
        a_set_en = 1'b1; a_set_addr = 5'd9;
        tick();
        idle();
        #1;
        chk("sb_set_wins", a_busy, 32'h0000_0200);
        a_we = 2'b01; a_wa = {5'd0, 5'd9}; a_wd = {32'd0, 32'h000000AA};
        #1;
        chk("sb_rd_busy_bypass", {31'd0, a_rd_busy[0]}, 32'd0);
        chk("sb_busyvec_held", a_busy, 32'h0000_0200);
        tick();
        idle();
        #1;
        chk("sb_cleared", a_busy, 32'h0);
        chk("sb_r9_data", a_rd[31:0], 32'h000000AA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
